pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_seq_pkg.sv | 18 +
 rtl/pc_sequencer.sv | 111 +++++++++++
 tb/tb_pc_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// Shared FSM encodings and default vectors for the PC sequencer.
// Imported by the sequencer RTL and its testbench.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10
    } state_e;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_sequencer.sv
// Fetch/execute PC sequencer with retire counter.
// Optional misaligned-target trap: define PC_SEQ_MISALIGN_TRAP_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    parameter logic [31:0] TRAP_VECTOR  = DEF_TRAP_VECTOR,
`endif
    parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    output logic [31:0] instr_addr,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic [31:0] next_pc,
    output logic [31:0] retire_count,
    output logic        trap,
    output logic [31:0] trap_addr
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] retire_count_q, retire_count_d;
    logic        imem_req_q, imem_req_d;
    logic        instr_valid_q, instr_valid_d;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    logic        trap_q, trap_d;
    logic [31:0] trap_addr_q, trap_addr_d;
`endif

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        retire_count_d = retire_count_q;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
        trap_d         = 1'b0;
        trap_addr_d    = trap_addr_q;
`endif
        // Stall freezes everything; events arriving under stall are dropped.
        if (!stall) begin
            unique case (state_q)
                ST_IDLE: state_d = ST_FETCH;
                ST_FETCH: begin
                    if (imem_ready) begin
                        state_d = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (exec_done) begin
                        state_d        = ST_FETCH;
                        retire_count_d = retire_count_q + 32'd1;
                        pc_d           = next_pc;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
                        if (is_misaligned(next_pc)) begin
                            pc_d        = TRAP_VECTOR;
                            trap_d      = 1'b1;
                            trap_addr_d = next_pc;
                        end
`endif
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        imem_req_d    = (state_d == ST_FETCH);
        instr_valid_d = (state_d == ST_EXEC);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            pc_q           <= RESET_VECTOR;
            retire_count_q <= 32'd0;
            imem_req_q     <= 1'b0;
            instr_valid_q  <= 1'b0;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
            trap_q         <= 1'b0;
            trap_addr_q    <= 32'd0;
`endif
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            retire_count_q <= retire_count_d;
            imem_req_q     <= imem_req_d;
            instr_valid_q  <= instr_valid_d;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
            trap_q         <= trap_d;
            trap_addr_q    <= trap_addr_d;
`endif
        end
    end

    assign imem_req     = imem_req_q;
    assign imem_addr    = pc_q;
    assign instr_addr   = pc_q;
    assign instr_valid  = instr_valid_q;
    assign retire_count = retire_count_q;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    assign trap         = trap_q;
    assign trap_addr    = trap_addr_q;
`else
    assign trap         = 1'b0;
    assign trap_addr    = 32'd0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer (default or trap build).
// Expected fetch addresses flow through a scoreboard queue.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] instr_addr;
    logic        instr_valid;
    logic        exec_done;
    logic [31:0] next_pc;
    logic [31:0] retire_count;
    logic        trap;
    logic [31:0] trap_addr;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];

    pc_sequencer dut (
        .clk(clk),
        .reset_n(reset_n),
        .stall(stall),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ready(imem_ready),
        .instr_addr(instr_addr),
        .instr_valid(instr_valid),
        .exec_done(exec_done),
        .next_pc(next_pc),
        .retire_count(retire_count),
        .trap(trap),
        .trap_addr(trap_addr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        stall = 1'b1;
        imem_ready = 1'b1;
        exec_done = 1'b1;
        next_pc = 32'h55;
        repeat (3) tick();
        vectors++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctl got req=%0b vld=%0b want 0 0", imem_req, instr_valid);
        end
        vectors++;
        if (imem_addr !== DEF_RESET_VECTOR || instr_addr !== DEF_RESET_VECTOR) begin
            miscompares++;
            $display("FAIL reset_pc got %h/%h want %h", imem_addr, instr_addr, DEF_RESET_VECTOR);
        end
        vectors++;
        if (retire_count !== 32'd0 || trap !== 1'b0 || trap_addr !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_cnt got cnt=%h trap=%0b taddr=%h want 0", retire_count, trap, trap_addr);
        end
        stall = 1'b0;
        imem_ready = 1'b0;
        exec_done = 1'b0;
        next_pc = 32'd0;
        reset_n = 1'b1;
    endtask

    task automatic test_sequential();
        logic [31:0] m_pc;
        logic [31:0] exp;
        int          retires;
        int          last_req;
        m_pc = DEF_RESET_VECTOR;
        retires = 0;
        last_req = -1;
        for (int k = 0; k < 4; k++) exp_q.push_back(32'(k * 4));
        imem_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && retires < 4; cyc++) begin
            tick();
            exec_done = 1'b0;
            if (imem_req === 1'b1) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                vectors++;
                if (imem_addr !== exp) begin
                    miscompares++;
                    $display("FAIL seq_addr got %h want %h", imem_addr, exp);
                end
                if (last_req >= 0) begin
                    vectors++;
                    if (cyc - last_req != 2) begin
                        miscompares++;
                        $display("FAIL seq_period got %0d want 2", cyc - last_req);
                    end
                end
                last_req = cyc;
            end
            if (instr_valid === 1'b1) begin
                exec_done = 1'b1;
                next_pc = m_pc + 32'd4;
                m_pc = m_pc + 32'd4;
                retires++;
            end
        end
        vectors++;
        if (retires != 4) begin
            miscompares++;
            $display("FAIL seq_timeout got %0d retires want 4", retires);
        end
        tick();
        exec_done = 1'b0;
        vectors++;
        if (retire_count !== 32'd4) begin
            miscompares++;
            $display("FAIL seq_count got %0d want 4", retire_count);
        end
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
            miscompares++;
            $display("FAIL seq_refetch got req=%0b addr=%h want 1 10", imem_req, imem_addr);
        end
        imem_ready = 1'b0;
    endtask

    task automatic test_ignored();
        exec_done = 1'b1;
        next_pc = 32'h300;
        tick();
        exec_done = 1'b0;
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h10 || retire_count !== 32'd4) begin
            miscompares++;
            $display("FAIL done_in_fetch got req=%0b addr=%h cnt=%0d want 1 10 4", imem_req, imem_addr, retire_count);
        end
    endtask

    task automatic test_ready_wait();
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h10 || instr_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL wait_hold%0d got req=%0b addr=%h vld=%0b want 1 10 0", k, imem_req, imem_addr, instr_valid);
            end
        end
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        vectors++;
        if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL wait_exec got vld=%0b req=%0b want 1 0", instr_valid, imem_req);
        end
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        vectors++;
        if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_in_exec got vld=%0b req=%0b want 1 0", instr_valid, imem_req);
        end
    endtask

    task automatic test_stall();
        exec_done = 1'b1;
        stall = 1'b1;
        next_pc = 32'h40;
        tick();
        vectors++;
        if (instr_valid !== 1'b1 || instr_addr !== 32'h10 || retire_count !== 32'd4) begin
            miscompares++;
            $display("FAIL stall_exec got vld=%0b pc=%h cnt=%0d want 1 10 4", instr_valid, instr_addr, retire_count);
        end
        stall = 1'b0;
        exp_q.push_back(32'h40);
        tick();
        exec_done = 1'b0;
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== exp_q.pop_front() || retire_count !== 32'd5) begin
            miscompares++;
            $display("FAIL stall_release got req=%0b addr=%h cnt=%0d want 1 40 5", imem_req, imem_addr, retire_count);
        end
        stall = 1'b1;
        imem_ready = 1'b1;
        tick();
        vectors++;
        if (imem_req !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== 32'h40) begin
            miscompares++;
            $display("FAIL stall_fetch got req=%0b vld=%0b addr=%h want 1 0 40", imem_req, instr_valid, imem_addr);
        end
        stall = 1'b0;
        tick();
        imem_ready = 1'b0;
        vectors++;
        if (instr_valid !== 1'b1 || instr_addr !== 32'h40) begin
            miscompares++;
            $display("FAIL stall_fetch_rel got vld=%0b pc=%h want 1 40", instr_valid, instr_addr);
        end
    endtask

    task automatic test_trap();
        exec_done = 1'b1;
        next_pc = 32'h0000_0042;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
        exp_q.push_back(DEF_TRAP_VECTOR);
`else
        exp_q.push_back(32'h42);
`endif
        tick();
        exec_done = 1'b0;
        vectors++;
        if (imem_addr !== exp_q.pop_front() || retire_count !== 32'd6) begin
            miscompares++;
            $display("FAIL trap_pc got addr=%h cnt=%0d", imem_addr, retire_count);
        end
        vectors++;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
        if (trap !== 1'b1 || trap_addr !== 32'h42) begin
            miscompares++;
            $display("FAIL trap_pulse got trap=%0b taddr=%h want 1 42", trap, trap_addr);
        end
`else
        if (trap !== 1'b0 || trap_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL trap_off got trap=%0b taddr=%h want 0 0", trap, trap_addr);
        end
`endif
        tick();
        vectors++;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
        if (trap !== 1'b0 || trap_addr !== 32'h42) begin
            miscompares++;
            $display("FAIL trap_after got trap=%0b taddr=%h want 0 42", trap, trap_addr);
        end
`else
        if (trap !== 1'b0 || trap_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL trap_after got trap=%0b taddr=%h want 0 0", trap, trap_addr);
        end
`endif
    endtask

    task automatic test_reset_mid();
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        exec_done = 1'b1;
        next_pc = 32'h80;
        tick();
        exec_done = 1'b0;
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        vectors++;
        if (instr_valid !== 1'b1 || instr_addr !== 32'h80) begin
            miscompares++;
            $display("FAIL mid_setup got vld=%0b pc=%h want 1 80", instr_valid, instr_addr);
        end
        reset_n = 1'b0;
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        vectors++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b0 || instr_addr !== DEF_RESET_VECTOR || retire_count !== 32'd0) begin
            miscompares++;
            $display("FAIL mid_reset got vld=%0b req=%0b pc=%h cnt=%0d want 0 0 %h 0", instr_valid, imem_req, instr_addr, retire_count, DEF_RESET_VECTOR);
        end
        vectors++;
        if (trap !== 1'b0 || trap_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL mid_reset_trap got trap=%0b taddr=%h want 0 0", trap, trap_addr);
        end
        reset_n = 1'b1;
        tick();
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== DEF_RESET_VECTOR) begin
            miscompares++;
            $display("FAIL mid_restart got req=%0b addr=%h want 1 %h", imem_req, imem_addr, DEF_RESET_VECTOR);
        end
    endtask

    task automatic test_wrap();
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        force dut.retire_count_d = 32'hFFFF_FFFF;
        tick();
        release dut.retire_count_d;
        #1;
        vectors++;
        if (retire_count !== 32'hFFFF_FFFF || instr_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_preload got cnt=%h vld=%0b want ffffffff 1", retire_count, instr_valid);
        end
        exec_done = 1'b1;
        next_pc = 32'hFFFF_FFFC;
        exp_q.push_back(32'hFFFF_FFFC);
        tick();
        exec_done = 1'b0;
        vectors++;
        if (retire_count !== 32'd0 || imem_addr !== exp_q.pop_front()) begin
            miscompares++;
            $display("FAIL wrap_count got cnt=%h addr=%h want 0 fffffffc", retire_count, imem_addr);
        end
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        exec_done = 1'b1;
        next_pc = 32'h0;
        exp_q.push_back(32'h0);
        tick();
        exec_done = 1'b0;
        vectors++;
        if (imem_addr !== exp_q.pop_front() || imem_req !== 1'b1 || retire_count !== 32'd1) begin
            miscompares++;
            $display("FAIL wrap_pc got addr=%h req=%0b cnt=%0d want 0 1 1", imem_addr, imem_req, retire_count);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_ignored();
        test_ready_wait();
        test_stall();
        test_trap();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
